// File: rtl/vout_fpdlink.sv
// vout_fpdlink: dual-channel FPD-Link 7:1 transmitter with internal panel timing, running in the bit-clock domain.
// Ports: clk/rst_n (bit clock, async active-low reset); pix_valid/pix_ready/pix_odd/pix_even (pixel-word handshake);
// clr_underflow/underflow (sticky starvation flag); frame_start (pulse on loading h=0,v=0);
// lvds_clk (forwarded clock lane); lvds_odd/lvds_even (three data lanes per channel, MSB-first).
module vout_fpdlink #(
    parameter int H_ACTIVE = 400,
    parameter int H_FP     = 20,
    parameter int H_SYNC   = 10,
    parameter int H_BP     = 20,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 20,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [17:0] pix_odd,
    input  logic [17:0] pix_even,
    input  logic        clr_underflow,
    output logic        underflow,
    output logic        frame_start,
    output logic        lvds_clk,
    output logic [2:0]  lvds_odd,
    output logic [2:0]  lvds_even
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic HS_LVL = 1'(HS_POL);
    localparam logic VS_LVL = 1'(VS_POL);

    // h_q/v_q name the word that will be loaded at the next s==6, not the one on the wire.
    logic [2:0]      s_q, s_d;
    logic [HW-1:0]   h_q, h_d;
    logic [VW-1:0]   v_q, v_d;
    logic            uf_q, uf_d;
    logic            clk_q, clk_d;
    logic [2:0][6:0] so_q, so_d, se_q, se_d;
    logic            load, de, hs, vs, take;
    logic [2:0]      ctl;
    logic [20:0]     wo, we;

    // Lane word layout: {g0, r[5:0], b[1:0], g[5:1], de, vs, hs, b[5:2]}.
    function automatic logic [20:0] pack(input logic [17:0] p, input logic [2:0] c);
        return {p[6], p[17:12], p[1:0], p[11:7], c, p[5:2]};
    endfunction

    always_comb begin
        load  = s_q == 3'd6;
        s_d   = load ? 3'd0 : s_q + 3'd1;
        de    = (h_q < H_ACT) && (v_q < V_ACT);
        hs    = (h_q >= HS_BEG) && (h_q < HS_END);
        vs    = (v_q >= VS_BEG) && (v_q < VS_END);
        take  = load && de && pix_valid;
        h_d   = !load ? h_q : (h_q == H_LAST) ? '0 : h_q + HW'(1);
        v_d   = !(load && h_q == H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + VW'(1);
        uf_d  = (load && de && !pix_valid) || (uf_q && !clr_underflow);
        // Registered one slot ahead so the clock lane lines up with the registered data lanes.
        clk_d = (s_d < 3'd2) || (s_d > 3'd4);
        ctl   = {de, vs ? VS_LVL : ~VS_LVL, hs ? HS_LVL : ~HS_LVL};
        wo    = pack(take ? pix_odd : 18'd0, ctl);
        we    = pack(take ? pix_even : 18'd0, ctl);
        so_d  = so_q;
        se_d  = se_q;
        for (int k = 0; k < 3; k++) begin
            so_d[k] = load ? wo[7*k +: 7] : {so_q[k][5:0], 1'b0};
            se_d[k] = load ? we[7*k +: 7] : {se_q[k][5:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= '0;
            h_q   <= '0;
            v_q   <= '0;
            uf_q  <= 1'b0;
            clk_q <= 1'b0;
            so_q  <= '0;
            se_q  <= '0;
        end else begin
            s_q   <= s_d;
            h_q   <= h_d;
            v_q   <= v_d;
            uf_q  <= uf_d;
            clk_q <= clk_d;
            so_q  <= so_d;
            se_q  <= se_d;
        end
    end

    assign pix_ready   = load && de;
    assign frame_start = load && h_q == '0 && v_q == '0;
    assign underflow   = uf_q;
    assign lvds_clk    = clk_q;
    assign lvds_odd    = {so_q[2][6], so_q[1][6], so_q[0][6]};
    assign lvds_even   = {se_q[2][6], se_q[1][6], se_q[0][6]};
endmodule

// File: tb/tb_vout_fpdlink.sv
// tb_vout_fpdlink: table-driven check of vout_fpdlink in a small 7x5-word raster, with an inverted-polarity twin.
module tb_vout_fpdlink;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_valid = 1'b0;
    logic [17:0] pix_odd = '0, pix_even = '0;
    logic        clr_underflow = 1'b0;
    logic        pix_ready, underflow, frame_start, lvds_clk;
    logic [2:0]  lvds_odd, lvds_even;
    logic        pix_ready_n, underflow_n, frame_start_n, lvds_clk_n;
    logic [2:0]  lvds_odd_n, lvds_even_n;
    int n_chk = 0, n_fail = 0, rdy_cnt = 0;

    always #5 clk = ~clk;

    vout_fpdlink #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .HS_POL(1), .VS_POL(1)) dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_odd(pix_odd),
        .pix_even(pix_even), .clr_underflow(clr_underflow), .underflow(underflow), .frame_start(frame_start),
        .lvds_clk(lvds_clk), .lvds_odd(lvds_odd), .lvds_even(lvds_even));

    vout_fpdlink #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .HS_POL(0), .VS_POL(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready_n), .pix_odd(pix_odd),
        .pix_even(pix_even), .clr_underflow(clr_underflow), .underflow(underflow_n), .frame_start(frame_start_n),
        .lvds_clk(lvds_clk_n), .lvds_odd(lvds_odd_n), .lvds_even(lvds_even_n));

    typedef struct {
        logic        v;
        logic [17:0] po, pe;
        logic        clr;
        logic [20:0] eo, ee;
        logic        fs, rdy, uf;
    } vec_t;
    vec_t tbl[14];

    function automatic vec_t mk(logic v, logic [17:0] po, logic [17:0] pe, logic clr, logic [20:0] eo,
                                logic [20:0] ee, logic fs, logic rdy, logic uf);
        vec_t r;
        r.v = v; r.po = po; r.pe = pe; r.clr = clr; r.eo = eo; r.ee = ee; r.fs = fs; r.rdy = rdy; r.uf = uf;
        return r;
    endfunction

    function automatic logic pat(int i);
        return i < 2 || i > 4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Entered in an s==6 cycle; drives the word to be loaded, deserializes it, and returns in the next s==6 cycle.
    task automatic run_word(input string nm, input vec_t t);
        logic [20:0] go, ge, gno, gne;
        logic clk_ok, rdy_ok, twin_ok;
        clk_ok = 1'b1; rdy_ok = 1'b1; twin_ok = 1'b1;
        go = '0; ge = '0; gno = '0; gne = '0;
        pix_valid = t.v; pix_odd = t.po; pix_even = t.pe; clr_underflow = t.clr;
        chk({nm, " frame_start"}, 32'(frame_start), 32'(t.fs));
        chk({nm, " pix_ready"}, 32'(pix_ready), 32'(t.rdy));
        if (pix_ready) rdy_cnt++;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            clr_underflow = 1'b0;
            if (lvds_clk !== pat(i) || lvds_clk_n !== pat(i)) clk_ok = 1'b0;
            if (i < 6 && (pix_ready !== 1'b0 || frame_start !== 1'b0)) rdy_ok = 1'b0;
            if (pix_ready_n !== pix_ready || frame_start_n !== frame_start) twin_ok = 1'b0;
            for (int k = 0; k < 3; k++) begin
                go[7*k+6-i]  = lvds_odd[k];
                ge[7*k+6-i]  = lvds_even[k];
                gno[7*k+6-i] = lvds_odd_n[k];
                gne[7*k+6-i] = lvds_even_n[k];
            end
        end
        chk({nm, " clk lane"}, 32'(clk_ok), 32'd1);
        chk({nm, " ready/fs off-slot"}, 32'(rdy_ok), 32'd1);
        chk({nm, " odd word"}, 32'(go), 32'(t.eo));
        chk({nm, " even word"}, 32'(ge), 32'(t.ee));
        chk({nm, " odd word inv pol"}, 32'(gno), 32'(t.eo ^ 21'h30));
        chk({nm, " even word inv pol"}, 32'(gne), 32'(t.ee ^ 21'h30));
        chk({nm, " twin ctrl"}, 32'(twin_ok && underflow_n === underflow), 32'd1);
        chk({nm, " underflow"}, 32'(underflow), 32'(t.uf));
    endtask

    // Entered right after rst_n release; returns in the first s==6 cycle.
    task automatic startup(input string nm);
        logic ok;
        ok = (lvds_odd === 3'd0) && (lvds_even === 3'd0) && (frame_start === 1'b0) && (pix_ready === 1'b0);
        for (int n = 1; n < 7; n++) begin
            @(posedge clk); #1;
            if (lvds_clk !== pat(n) || lvds_odd !== 3'd0 || lvds_even !== 3'd0) ok = 1'b0;
            if (frame_start !== (n == 6) || pix_ready !== (n == 6)) ok = 1'b0;
        end
        chk({nm, " startup sequence"}, 32'(ok), 32'd1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " lanes"}, {26'd0, lvds_clk, lvds_odd, lvds_even}, 32'd0);
        chk({nm, " ctrl"}, {29'd0, pix_ready, underflow, frame_start}, 32'd0);
    endtask

    initial begin
        vec_t t;
        logic [20:0] e;
        // Line 0: h0-3 active, h4 FP, h5 hsync, h6 BP.
        tbl[0]  = mk(1, 18'h3F000, 18'h00FC0, 0, 21'h0FC040, 21'h100FC0, 1, 1, 0);
        tbl[1]  = mk(1, 18'h0003F, 18'h2A555, 0, 21'h00304F, 21'h1A9545, 0, 1, 0);
        tbl[2]  = mk(0, 18'h3FFFF, 18'h3FFFF, 0, 21'h000040, 21'h000040, 0, 1, 1);
        tbl[3]  = mk(1, 18'h3FFFF, 18'h3FFFF, 0, 21'h1FFFCF, 21'h1FFFCF, 0, 1, 1);
        tbl[4]  = mk(1, 18'h3FFFF, 18'h3FFFF, 0, 21'h000000, 21'h000000, 0, 0, 1);
        tbl[5]  = mk(1, 18'h3FFFF, 18'h3FFFF, 0, 21'h000010, 21'h000010, 0, 0, 1);
        tbl[6]  = mk(1, 18'h3FFFF, 18'h3FFFF, 0, 21'h000000, 21'h000000, 0, 0, 1);
        for (int j = 7; j < 11; j++) tbl[j] = mk(1, 18'h3F000, 18'h00FC0, 0, 21'h0FC040, 21'h100FC0, 0, 1, 1);
        tbl[11] = mk(1, 18'h3F000, 18'h00FC0, 0, 21'h000000, 21'h000000, 0, 0, 1);
        tbl[12] = mk(1, 18'h3F000, 18'h00FC0, 0, 21'h000010, 21'h000010, 0, 0, 1);
        tbl[13] = mk(1, 18'h3F000, 18'h00FC0, 0, 21'h000000, 21'h000000, 0, 0, 1);

        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        startup("boot");
        for (int j = 0; j < 14; j++) run_word($sformatf("w%0d", j), tbl[j]);
        // Lines 2..4 are blank: FP, vsync, BP. Pixels offered must be ignored; clear the flag on the first word.
        for (int l = 2; l < 5; l++) begin
            for (int h = 0; h < 7; h++) begin
                e = (l == 3 ? 21'h20 : 21'h0) | (h == 5 ? 21'h10 : 21'h0);
                t = mk(1, 18'h3FFFF, 18'h3FFFF, (l == 2 && h == 0), e, e, 0, 0, !(l > 2 || h > 0) ? 1'b0 : 1'b0);
                run_word($sformatf("line%0d h%0d", l, h), t);
            end
        end
        chk("ready count per frame", 32'(rdy_cnt), 32'd8);
        // New frame: underflow coinciding with a clear must leave the flag set.
        run_word("f2 w0 uf+clr", mk(0, 18'h3F000, 18'h00FC0, 1, 21'h000040, 21'h000040, 1, 1, 1));
        run_word("f2 w1", mk(1, 18'h3F000, 18'h00FC0, 0, 21'h0FC040, 21'h100FC0, 0, 1, 1));
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("mid-word reset");
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        chk_zero("post-release");
        startup("restart");
        run_word("restart w0", mk(1, 18'h3F000, 18'h00FC0, 0, 21'h0FC040, 21'h100FC0, 1, 1, 0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
